// File: rtl/icg_bank_pkg.sv
// -----------------------------------------------------------------------------
// icg_bank_pkg
// Shared constants and helpers for the hysteresis clock-gate bank.
//   HOLD_MAX   : largest supported hold-on count
//   N_CH_MAX   : largest supported number of channels
//   clog2_min1 : width needed to hold 0..value, never less than 1 bit
// -----------------------------------------------------------------------------
package icg_bank_pkg;

  localparam int HOLD_MAX = 255;
  localparam int N_CH_MAX = 32;

  // Bits needed to represent 0..value. A zero hold still gets a 1-bit
  // counter so the channel keeps a uniform structure.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 16; i++) begin
      if ((1 << i) < value + 1) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/icg_hyst_chan.sv
// -----------------------------------------------------------------------------
// icg_hyst_chan
// One gated-clock channel with a hold-on counter.
//   clk_i   : source clock
//   rst_ni  : asynchronous active-low reset
//   te_i    : test enable, forces the channel on
//   en_i    : functional enable request
//   gclk_o  : gated clock (clk_i AND low-phase latch of the request)
//   gated_o : registered status, 1 = channel gated off
// The channel keeps running for HOLD cycles after en_i drops.
// -----------------------------------------------------------------------------
module icg_hyst_chan
  import icg_bank_pkg::*;
#(
  parameter int HOLD = 3,
  parameter int CW   = clog2_min1(HOLD)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic te_i,
  input  logic en_i,
  output logic gclk_o,
  output logic gated_o
);

  localparam logic [CW-1:0] HOLD_V = CW'(HOLD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          gated_q;
  logic          lat_q;
  logic          req;

  // Reload on enable, otherwise count down and stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = HOLD_V;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Test enable is OR-ed in asynchronously; it does not touch the counter.
  assign req = en_i | (cnt_q != '0) | te_i;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      gated_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      gated_q <= ~req;
    end
  end

  // NOTE: this latch is intentional. It is transparent only while clk_i is
  // low, so request changes during the high phase cannot cut or create a
  // pulse. Reset clears it asynchronously, and after reset release during a
  // high phase it stays closed until the next low phase.
  always_latch begin
    if (!rst_ni) begin
      lat_q <= 1'b0;
    end else if (!clk_i) begin
      lat_q <= req;
    end
  end

  assign gclk_o  = clk_i & lat_q;
  assign gated_o = gated_q;

`ifndef FUNCTIONAL
  // Timing checks for gate-level style simulation.
  logic notifier;
  specify
    $setuphold(posedge clk_i, en_i, 0, 0, notifier);
    $setuphold(posedge clk_i, te_i, 0, 0, notifier);
    $width(negedge clk_i, 0, 0, notifier);
    $recrem(posedge rst_ni, posedge clk_i, 0, 0, notifier);
  endspecify
`endif

endmodule

// File: rtl/icg_bank_hyst.sv
// -----------------------------------------------------------------------------
// icg_bank_hyst
// Bank of N_CH independent clock gates with test enable and hold-on
// counters, fed from one shared clock.
//   CLK   : source clock
//   RN    : asynchronous active-low reset
//   TE    : test enable, forces every channel on
//   E     : per-channel enable request [N_CH]
//   Q     : per-channel gated clocks [N_CH]
//   GATED : per-channel registered status, 1 = gated off [N_CH]
// -----------------------------------------------------------------------------
module icg_bank_hyst
  import icg_bank_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int HOLD = 3
) (
  input  logic            CLK,
  input  logic            RN,
  input  logic            TE,
  input  logic [N_CH-1:0] E,
  output logic [N_CH-1:0] Q,
  output logic [N_CH-1:0] GATED
);

  localparam int CW = clog2_min1(HOLD);

  if (N_CH < 1 || N_CH > N_CH_MAX) begin : g_bad_n_ch
    $error("icg_bank_hyst: N_CH out of range");
  end
  if (HOLD < 0 || HOLD > HOLD_MAX) begin : g_bad_hold
    $error("icg_bank_hyst: HOLD out of range");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    icg_hyst_chan #(
      .HOLD (HOLD),
      .CW   (CW)
    ) u_chan (
      .clk_i   (CLK),
      .rst_ni  (RN),
      .te_i    (TE),
      .en_i    (E[i]),
      .gclk_o  (Q[i]),
      .gated_o (GATED[i])
    );
  end

endmodule

// File: tb/tb_icg_bank_hyst.sv
// -----------------------------------------------------------------------------
// tb_icg_bank_hyst
// Directed bench for icg_bank_hyst: a 4-channel HOLD=3 instance and a
// 1-channel HOLD=0 instance share the clock and reset. Clock period 10,
// high phase 5 starting at each posedge. Inputs change mid-phase.
// -----------------------------------------------------------------------------
module tb_icg_bank_hyst;

  localparam int HALF = 5;

  logic       CLK = 1'b0;
  logic       RN;
  logic       TE;
  logic [3:0] E;
  logic [3:0] Q;
  logic [3:0] GATED;

  logic       te0;
  logic [0:0] e0;
  logic [0:0] q0;
  logic [0:0] gated0;

  int errors = 0;
  int checks = 0;

  // Pulse-width monitor on Q[2].
  logic pw_en     = 1'b0;
  logic rise_seen = 1'b0;
  time  t_rise;
  int   pw_pulses = 0;

  always #HALF CLK = ~CLK;

  icg_bank_hyst #(.N_CH(4), .HOLD(3)) u_dut (
    .CLK   (CLK),
    .RN    (RN),
    .TE    (TE),
    .E     (E),
    .Q     (Q),
    .GATED (GATED)
  );

  icg_bank_hyst #(.N_CH(1), .HOLD(0)) u_dut0 (
    .CLK   (CLK),
    .RN    (RN),
    .TE    (te0),
    .E     (e0),
    .Q     (q0),
    .GATED (gated0)
  );

  always @(posedge Q[2]) begin
    t_rise    = $time;
    rise_seen = 1'b1;
  end

  always @(negedge Q[2]) begin
    if (pw_en && rise_seen) begin
      checks++;
      pw_pulses++;
      if ($time - t_rise != HALF) begin
        errors++;
        $display("FAIL pulse_width_q2: got %0t, want %0d (fall at %0t)",
                 $time - t_rise, HALF, $time);
      end
    end
  end

  task automatic to_mid_high();
    @(posedge CLK);
    #2;
  endtask

  task automatic to_mid_low();
    @(negedge CLK);
    #2;
  endtask

  task automatic test_reset();
    RN  = 1'b1;
    TE  = 1'b1;
    E   = 4'hF;
    te0 = 1'b1;
    e0  = 1'b1;
    #1 RN = 1'b0;
    repeat (3) begin
      to_mid_high();
      checks++;
      if (Q !== 4'h0) begin
        errors++; $display("FAIL reset_q_high: got %h, want 0", Q);
      end
      checks++;
      if (GATED !== 4'hF) begin
        errors++; $display("FAIL reset_gated: got %h, want f", GATED);
      end
      checks++;
      if (q0 !== 1'b0) begin
        errors++; $display("FAIL reset_q0: got %b, want 0", q0);
      end
      to_mid_low();
      checks++;
      if (Q !== 4'h0) begin
        errors++; $display("FAIL reset_q_low: got %h, want 0", Q);
      end
    end
    // Release during the high phase: no partial pulse this phase.
    to_mid_high();
    RN = 1'b1;
    #1;
    checks++;
    if (Q !== 4'h0) begin
      errors++; $display("FAIL release_no_partial: got %h, want 0", Q);
    end
    checks++;
    if (GATED !== 4'hF) begin
      errors++; $display("FAIL release_gated: got %h, want f", GATED);
    end
    to_mid_high();
    checks++;
    if (Q !== 4'hF) begin
      errors++; $display("FAIL release_first_pulse: got %h, want f", Q);
    end
    checks++;
    if (GATED !== 4'h0) begin
      errors++; $display("FAIL release_gated_clear: got %h, want 0", GATED);
    end
    // Reset mid-pulse drops Q immediately.
    #1 RN = 1'b0;
    #1;
    checks++;
    if (Q !== 4'h0) begin
      errors++; $display("FAIL midpulse_reset_q: got %h, want 0", Q);
    end
    checks++;
    if (GATED !== 4'hF) begin
      errors++; $display("FAIL midpulse_reset_gated: got %h, want f", GATED);
    end
    to_mid_low();
    E   = 4'h0;
    TE  = 1'b0;
    e0  = 1'b0;
    te0 = 1'b0;
    RN  = 1'b1;
    to_mid_high();
    checks++;
    if (Q !== 4'h0) begin
      errors++; $display("FAIL idle_after_reset: got %h, want 0", Q);
    end
    checks++;
    if (GATED !== 4'hF) begin
      errors++; $display("FAIL idle_gated: got %h, want f", GATED);
    end
  endtask

  // E[0] high for two posedges: 2 + HOLD = 5 pulses, then gated.
  task automatic test_hysteresis();
    logic [7:0] e_v;
    logic [7:0] q_v;
    logic [7:0] g_v;
    logic [3:0] exp_q;
    logic [3:0] exp_g;
    e_v = 8'b0000_0011;
    q_v = 8'b0001_1111;
    g_v = 8'b1110_0000;
    for (int c = 0; c < 8; c++) begin
      to_mid_low();
      checks++;
      if (Q !== 4'h0) begin
        errors++; $display("FAIL hyst_low_c%0d: got %h, want 0", c, Q);
      end
      E = {3'b000, e_v[c]};
      to_mid_high();
      exp_q = {3'b000, q_v[c]};
      exp_g = {3'b111, g_v[c]};
      checks++;
      if (Q !== exp_q) begin
        errors++; $display("FAIL hyst_q_c%0d: got %h, want %h", c, Q, exp_q);
      end
      checks++;
      if (GATED !== exp_g) begin
        errors++; $display("FAIL hyst_gated_c%0d: got %h, want %h", c, GATED, exp_g);
      end
    end
  endtask

  // E[1] drops, re-asserts when the counter is at 1: never gates.
  task automatic test_retrigger();
    logic [7:0] e_v;
    logic [7:0] q_v;
    logic [7:0] g_v;
    logic [3:0] exp_q;
    logic [3:0] exp_g;
    e_v = 8'b0000_1001;
    q_v = 8'b0111_1111;
    g_v = 8'b1000_0000;
    for (int c = 0; c < 8; c++) begin
      to_mid_low();
      E = {2'b00, e_v[c], 1'b0};
      to_mid_high();
      exp_q = {2'b00, q_v[c], 1'b0};
      exp_g = {2'b11, g_v[c], 1'b1};
      checks++;
      if (Q !== exp_q) begin
        errors++; $display("FAIL retrig_q_c%0d: got %h, want %h", c, Q, exp_q);
      end
      checks++;
      if (GATED !== exp_g) begin
        errors++; $display("FAIL retrig_gated_c%0d: got %h, want %h", c, GATED, exp_g);
      end
    end
  endtask

  // Toggle E[2] and TE at random offsets inside both phases.
  task automatic test_glitch();
    int unsigned off;
    to_mid_low();
    pw_en     = 1'b1;
    pw_pulses = 0;
    repeat (60) begin
      @(posedge CLK);
      off = $urandom_range(1, 4);
      #(off);
      E[2] = 1'($urandom_range(0, 1));
      TE   = ($urandom_range(0, 3) == 0);
      @(negedge CLK);
      off = $urandom_range(1, 4);
      #(off);
      E[2] = 1'($urandom_range(0, 1));
      TE   = ($urandom_range(0, 3) == 0);
    end
    to_mid_low();
    E  = 4'h0;
    TE = 1'b0;
    repeat (6) to_mid_low();
    pw_en = 1'b0;
    checks++;
    if (pw_pulses == 0) begin
      errors++; $display("FAIL glitch_pulses_seen: got %0d, want >0", pw_pulses);
    end
    to_mid_high();
    checks++;
    if (GATED !== 4'hF) begin
      errors++; $display("FAIL glitch_drained_gated: got %h, want f", GATED);
    end
  endtask

  task automatic test_test_enable();
    pw_en = 1'b1;
    to_mid_high();
    TE = 1'b1;
    #1;
    checks++;
    if (Q !== 4'h0) begin
      errors++; $display("FAIL te_rise_midhigh: got %h, want 0", Q);
    end
    checks++;
    if (GATED !== 4'hF) begin
      errors++; $display("FAIL te_rise_gated: got %h, want f", GATED);
    end
    to_mid_low();
    checks++;
    if (Q !== 4'h0) begin
      errors++; $display("FAIL te_low_phase: got %h, want 0", Q);
    end
    to_mid_high();
    checks++;
    if (Q !== 4'hF) begin
      errors++; $display("FAIL te_on_q: got %h, want f", Q);
    end
    checks++;
    if (GATED !== 4'h0) begin
      errors++; $display("FAIL te_on_gated: got %h, want 0", GATED);
    end
    to_mid_high();
    TE = 1'b0;
    #1;
    checks++;
    if (Q !== 4'hF) begin
      errors++; $display("FAIL te_fall_no_trunc: got %h, want f", Q);
    end
    to_mid_high();
    checks++;
    if (Q !== 4'h0) begin
      errors++; $display("FAIL te_off_q: got %h, want 0", Q);
    end
    checks++;
    if (GATED !== 4'hF) begin
      errors++; $display("FAIL te_off_gated: got %h, want f", GATED);
    end
    to_mid_low();
    pw_en = 1'b0;
  endtask

  // HOLD=0 single channel: plain gate. High-phase Q equals the request
  // value left at the end of the preceding low phase.
  task automatic test_hold0();
    logic exp_v;
    for (int c = 0; c < 1000; c++) begin
      to_mid_low();
      checks++;
      if (q0 !== 1'b0) begin
        errors++; $display("FAIL hold0_low_c%0d: got %b, want 0", c, q0);
      end
      e0[0] = 1'($urandom_range(0, 1));
      te0   = 1'($urandom_range(0, 1));
      exp_v = e0[0] | te0;
      to_mid_high();
      checks++;
      if (q0[0] !== exp_v) begin
        errors++; $display("FAIL hold0_q_c%0d: got %b, want %b", c, q0, exp_v);
      end
      checks++;
      if (gated0[0] !== ~exp_v) begin
        errors++; $display("FAIL hold0_gated_c%0d: got %b, want %b", c, gated0, ~exp_v);
      end
      #1;
      e0[0] = 1'($urandom_range(0, 1));
      te0   = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (q0[0] !== exp_v) begin
        errors++; $display("FAIL hold0_q_late_c%0d: got %b, want %b", c, q0, exp_v);
      end
    end
    to_mid_low();
    e0  = 1'b0;
    te0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_hysteresis();
    test_retrigger();
    test_glitch();
    test_test_enable();
    test_hold0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
